mvm_sequencer: RTL
==================

MVM_SEQUENCER -- requirements
Module: mvm_sequencer

Interface
REQ-001 SHALL have parameter M, default 4: matrix rows (output elements), 1..64.
REQ-002 SHALL have parameter N, default 4: matrix columns (terms per dot product), 1..64.
REQ-003 SHALL have parameter CLR_CYC, default 3: cycles mac_reset is held per row.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle request to compute y = W*x.
REQ-007 SHALL have port busy, output, 1: high from accepted start until done.
REQ-008 SHALL have port done, output, 1: one-cycle pulse after the last row is accepted.
REQ-009 SHALL have port w_addr, output, clog2(M*N): weight memory address, row-major (r*N+c).
REQ-010 SHALL have port x_addr, output, clog2(N): vector memory address.
REQ-011 SHALL have port mem_re, output, 1: read enable for both memories; data returns next cycle.
REQ-012 SHALL have ports w_rdata and x_rdata, input, 14 each, signed: memory read data.
REQ-013 SHALL have ports mac_a and mac_b, output, 14 each, signed: MAC operands.
REQ-014 SHALL have port mac_valid_in, output, 1: MAC operand-valid strobe.
REQ-015 SHALL have port mac_reset, output, 1: clear request to the MAC accumulator.
REQ-016 SHALL have ports mac_f (input, 28, signed) and mac_valid_out (input, 1): MAC result and its valid strobe.
REQ-017 SHALL have ports y_data (output, 28, signed), y_idx (output, clog2(M)), y_valid (output, 1) and y_ready (input, 1): result stream.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, OUT.
REQ-019 IDLE: start=1 -> CLEAR with row=0 and busy=1; start is ignored in every other state.
REQ-020 CLEAR: mac_reset=1 for exactly CLR_CYC cycles, then -> FEED with col=0.
REQ-021 FEED: mem_re=1 each cycle with w_addr=row*N+col and x_addr=col; col increments; after col=N-1 issues -> DRAIN.
REQ-022 Each read SHALL register mac_valid_in=1 one cycle after its mem_re, with mac_a=w_rdata and mac_b=x_rdata passed combinationally; operands are 0 when mac_valid_in=0.
REQ-023 SHALL count mac_valid_out pulses per row, with the count starting at CLEAR entry; on the N-th pulse it SHALL latch mac_f into y_data, set y_idx=row, y_valid=1 and go -> OUT.
REQ-024 OUT: y_valid and y_data SHALL be held stable until y_ready=1; the handshake completes in the cycle that has y_valid&y_ready.
REQ-025 On handshake in OUT: if row<M-1 then row++ -> CLEAR; else done=1 for one cycle, busy=0 -> IDLE.
REQ-026 y_ready=1 arriving in the same cycle y_valid rises SHALL complete the handshake that cycle.
REQ-027 N=1 and M=1 SHALL work (a single read, a single pulse to count).
REQ-028 mac_valid_out pulses seen outside FEED/DRAIN SHALL be ignored.
REQ-029 Saturation is performed by the MAC; the block SHALL pass mac_f through unmodified.
REQ-030 Minimum row period SHALL be CLR_CYC + N + MAC latency + 2 cycles.

Reset
REQ-031 reset=1 SHALL force IDLE and set row=0, col=0 and the pulse count to 0, from any state including mid-FEED or mid-OUT.
REQ-032 During reset, all outputs SHALL be 0, except mac_reset, which SHALL be 1.
REQ-033 The first cycle after reset SHALL accept start.

Structure
REQ-034 Package mvm_seq_pkg SHALL hold the state enum, DATA_W=14 and ACC_W=28.
REQ-035 The block SHALL be a single module with no sub-module; the MAC is instantiated beside it by the integrator.

Verification
REQ-036 W=[[1,2],[3,4]], x=[5,6], M=N=2, y_ready=1 -> y stream (idx0,17), (idx1,39), then one done pulse.
REQ-037 W all 8191, x all 8191, N=4, M=1 -> y_data=134217727 (saturated by the MAC).
REQ-038 y_ready=0 for 10 cycles during OUT -> y_data/y_idx stable, mem_re=0; the row advances only after y_ready=1.
REQ-039 start pulsed while busy -> ignored; exactly M results and one done pulse.
REQ-040 reset asserted in FEED at col=2 -> next cycle IDLE with all outputs 0; a new start then gives the correct full result.
REQ-041 Row-boundary check: the second row's result excludes the first row's products (W=[[1,1],[0,0]], x=[7,7] -> 14, 0).

Source files
------------

// File: rtl/mvm_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mvm_seq_pkg
// Brief    : Shared widths, FSM state encoding and width helper for mvm_sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package mvm_seq_pkg;

  localparam int DATA_W = 14;
  localparam int ACC_W  = 28;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Index width for a range of 'count' values; never narrower than one bit.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mvm_sequencer
// Brief    : Row-by-row y = W*x sequencer feeding an external MAC and streaming
//            each dot product out through a valid/ready port.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mvm_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int CLR_CYC = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [width_of(M*N)-1:0]      w_addr,
  output logic [width_of(N)-1:0]        x_addr,
  output logic                          mem_re,
  input  logic signed [DATA_W-1:0]      w_rdata,
  input  logic signed [DATA_W-1:0]      x_rdata,
  output logic signed [DATA_W-1:0]      mac_a,
  output logic signed [DATA_W-1:0]      mac_b,
  output logic                          mac_valid_in,
  output logic                          mac_reset,
  input  logic signed [ACC_W-1:0]       mac_f,
  input  logic                          mac_valid_out,
  output logic signed [ACC_W-1:0]       y_data,
  output logic [width_of(M)-1:0]        y_idx,
  output logic                          y_valid,
  input  logic                          y_ready
);

  localparam int AW = width_of(M*N);
  localparam int XW = width_of(N);
  localparam int RW = width_of(M);
  localparam int PW = width_of(N);
  localparam int CW = width_of(CLR_CYC);

  localparam logic [XW-1:0] COL_LAST  = XW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(M - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(N - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);

  state_t state;
  state_t state_next;

  logic [RW-1:0]           row;
  logic [XW-1:0]           col;
  logic [PW-1:0]           pcnt;
  logic [CW-1:0]           clr_cnt;
  logic signed [ACC_W-1:0] y_data_reg;
  logic [RW-1:0]           y_idx_reg;
  logic                    done_reg;
  logic                    rd_valid;
  logic                    last_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    last_pulse = 1'b0;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   if (clr_cnt == CLR_LAST) state_next = FEED;
      FEED:    if (col == COL_LAST) state_next = DRAIN;
      DRAIN:   state_next = DRAIN;
      OUT:     if (y_ready) state_next = (row == ROW_LAST) ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
    // MAC results only count while this row's operands are in flight.
    if ((state == FEED || state == DRAIN) && mac_valid_out && (pcnt == PCNT_LAST)) begin
      last_pulse = 1'b1;
      state_next = OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      col        <= '0;
      pcnt       <= '0;
      clr_cnt    <= '0;
      y_data_reg <= '0;
      y_idx_reg  <= '0;
      done_reg   <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      done_reg <= (state == OUT) && y_ready && (row == ROW_LAST);
      rd_valid <= (state == FEED);
      case (state)
        IDLE: begin
          row     <= '0;
          col     <= '0;
          pcnt    <= '0;
          clr_cnt <= '0;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + CW'(1);
          col     <= '0;
          pcnt    <= '0;
        end
        FEED, DRAIN: begin
          if (state == FEED) col <= col + XW'(1);
          if (mac_valid_out) pcnt <= pcnt + PW'(1);
        end
        OUT: begin
          if (y_ready) begin
            clr_cnt <= '0;
            if (row != ROW_LAST) row <= row + RW'(1);
          end
        end
        default: ;
      endcase
      if (last_pulse) begin
        y_data_reg <= mac_f;
        y_idx_reg  <= row;
      end
    end
  end

  // Every output except mac_reset is forced low while reset is applied.
  assign busy         = (state != IDLE) && !reset;
  assign mem_re       = (state == FEED) && !reset;
  assign w_addr       = mem_re ? AW'(int'(row) * N + int'(col)) : '0;
  assign x_addr       = mem_re ? col : '0;
  assign mac_valid_in = rd_valid && !reset;
  assign mac_a        = mac_valid_in ? w_rdata : '0;
  assign mac_b        = mac_valid_in ? x_rdata : '0;
  assign mac_reset    = reset || (state == CLEAR);
  assign y_valid      = (state == OUT) && !reset;
  assign y_data       = reset ? '0 : y_data_reg;
  assign y_idx        = reset ? '0 : y_idx_reg;
  assign done         = done_reg && !reset;

endmodule
`default_nettype wire
